ordered_merge_dedup: RTL

- Hamming-sequence merge stage. It takes two packetized, ascending-sorted Avalon-ST streams (A and B) and produces one packetized, strictly ascending stream with duplicates removed.
- The output feeds the stream-to-memory-mapped adapter directly, so out_sop and out_eop frame exactly one merged packet per input packet pair.
- Both inputs and the output use ready latency 0.

---
 rtl/hamming_pkg.sv | 20 ++
 rtl/st_output_reg.sv | 44 ++++
 rtl/ordered_merge_dedup.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/hamming_pkg.sv
// Shared types for the Hamming-sequence merge stage: merge FSM states and the
// output beat record.
package hamming_pkg;

  localparam int BEAT_WIDTH = 8;

  typedef enum logic [2:0] {
    WAIT_SOP = 3'b001,
    MERGE    = 3'b010,
    FLUSH    = 3'b100
  } merge_state_t;

  // Beat data is BEAT_WIDTH wide, so the merge stage must use WIDTH == BEAT_WIDTH.
  typedef struct packed {
    logic [BEAT_WIDTH-1:0] data;
    logic                  sop;
    logic                  eop;
  } beat_t;

endpackage

// File: rtl/st_output_reg.sv
// One-entry Avalon-ST output register (ready latency 0). It holds its beat
// while stalled and reports out_free when a new beat may be loaded.
module st_output_reg
  import hamming_pkg::*;
(
  input  logic  clock,
  input  logic  reset_n,
  input  logic  load,
  input  beat_t load_beat,
  input  logic  out_ready,
  output logic  out_valid,
  output beat_t out_beat,
  output logic  out_free
);

  logic  valid_q, valid_d;
  beat_t beat_q, beat_d;

  always_comb begin
    valid_d = valid_q;
    beat_d  = beat_q;
    if (load) begin
      valid_d = 1'b1;
      beat_d  = load_beat;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= 1'b0;
      beat_q  <= '0;
    end else begin
      valid_q <= valid_d;
      beat_q  <= beat_d;
    end
  end

  assign out_valid = valid_q;
  assign out_beat  = beat_q;
  assign out_free  = !valid_q || out_ready;

endmodule

// File: rtl/ordered_merge_dedup.sv
// Merges two ascending-sorted packetized streams into one strictly ascending
// packet, dropping duplicates via a single pending-candidate register.
module ordered_merge_dedup
  import hamming_pkg::*;
#(
  parameter int WIDTH = BEAT_WIDTH
) (
  input  logic             clock,
  input  logic             reset_n,
  output logic             a_ready,
  input  logic             a_valid,
  input  logic [WIDTH-1:0] a_data,
  input  logic             a_sop,
  input  logic             a_eop,
  output logic             b_ready,
  input  logic             b_valid,
  input  logic [WIDTH-1:0] b_data,
  input  logic             b_sop,
  input  logic             b_eop,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_sop,
  output logic             out_eop
);

  merge_state_t     state_q, state_d;
  logic             first_q, first_d;
  logic             a_done_q, a_done_d;
  logic             b_done_q, b_done_d;
  logic             pend_valid_q, pend_valid_d;
  logic [WIDTH-1:0] pend_q, pend_d;

  logic             take_a, take_b;
  logic             cand_avail, need_move, consume;
  logic [WIDTH-1:0] cand;
  logic             load;
  beat_t            load_beat;
  beat_t            out_beat;
  logic             out_free;

  // Equal heads are consumed together so they collapse into one candidate.
  always_comb begin
    take_a = 1'b0;
    take_b = 1'b0;
    cand   = '0;
    if (!a_done_q && !b_done_q) begin
      if (a_valid && b_valid) begin
        if (a_data < b_data) begin
          take_a = 1'b1;
          cand   = a_data;
        end else if (b_data < a_data) begin
          take_b = 1'b1;
          cand   = b_data;
        end else begin
          take_a = 1'b1;
          take_b = 1'b1;
          cand   = a_data;
        end
      end
    end else if (!a_done_q) begin
      take_a = a_valid;
      cand   = a_data;
    end else if (!b_done_q) begin
      take_b = b_valid;
      cand   = b_data;
    end
  end

  assign cand_avail = take_a || take_b;
  assign need_move  = pend_valid_q && (cand > pend_q);
  assign consume    = (state_q == MERGE) && cand_avail && (!need_move || out_free);

  always_comb begin
    a_ready = 1'b0;
    b_ready = 1'b0;
    if (reset_n) begin
      case (state_q)
        WAIT_SOP: begin
          a_ready = a_valid && !a_sop;
          b_ready = b_valid && !b_sop;
        end
        MERGE: begin
          a_ready = consume && take_a;
          b_ready = consume && take_b;
        end
        default: begin
          a_ready = 1'b0;
          b_ready = 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    state_d      = state_q;
    first_d      = first_q;
    a_done_d     = a_done_q;
    b_done_d     = b_done_q;
    pend_valid_d = pend_valid_q;
    pend_d       = pend_q;
    load         = 1'b0;
    load_beat    = '0;
    case (state_q)
      WAIT_SOP: begin
        if (a_valid && a_sop && b_valid && b_sop) begin
          state_d      = MERGE;
          first_d      = 1'b1;
          a_done_d     = 1'b0;
          b_done_d     = 1'b0;
          pend_valid_d = 1'b0;
        end
      end
      MERGE: begin
        if (consume) begin
          // Candidates equal to (or below) pend are dropped without output activity.
          if (!pend_valid_q) begin
            pend_d       = cand;
            pend_valid_d = 1'b1;
          end else if (need_move) begin
            load      = 1'b1;
            load_beat = '{data: pend_q, sop: first_q, eop: 1'b0};
            first_d   = 1'b0;
            pend_d    = cand;
          end
          if (take_a && a_eop) a_done_d = 1'b1;
          if (take_b && b_eop) b_done_d = 1'b1;
          if (a_done_d && b_done_d) state_d = FLUSH;
        end
      end
      FLUSH: begin
        if (!pend_valid_q) begin
          state_d = WAIT_SOP;
        end else if (out_free) begin
          load         = 1'b1;
          load_beat    = '{data: pend_q, sop: first_q, eop: 1'b1};
          first_d      = 1'b0;
          pend_valid_d = 1'b0;
          state_d      = WAIT_SOP;
        end
      end
      default: state_d = WAIT_SOP;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= WAIT_SOP;
      first_q      <= 1'b0;
      a_done_q     <= 1'b0;
      b_done_q     <= 1'b0;
      pend_valid_q <= 1'b0;
      pend_q       <= '0;
    end else begin
      state_q      <= state_d;
      first_q      <= first_d;
      a_done_q     <= a_done_d;
      b_done_q     <= b_done_d;
      pend_valid_q <= pend_valid_d;
      pend_q       <= pend_d;
    end
  end

  st_output_reg u_out_reg (
    .clock     (clock),
    .reset_n   (reset_n),
    .load      (load),
    .load_beat (load_beat),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_beat  (out_beat),
    .out_free  (out_free)
  );

  assign out_data = out_beat.data;
  assign out_sop  = out_beat.sop;
  assign out_eop  = out_beat.eop;

  // Out-of-order input is a protocol violation; it is dropped like a duplicate.
  assert property (@(posedge clock) disable iff (!reset_n)
    !(consume && pend_valid_q && (cand < pend_q)));

endmodule
